// File: rtl/wb_select_queue.sv
//------------------------------------------------------------------------------
// wb_select_queue
//
// Write-back source selector feeding a small valid/ready queue towards the
// register file of the multicycle datapath. Each accepted transaction picks
// one of NUM_SRC sources (or the DEFAULT_VAL constant), captures it together
// with the destination register address, and queues it for the consumer.
// Illegal selects are made safe by returning DEFAULT_VAL and raising a sticky
// error flag. With DROP_ZERO set, writes to register 0 complete the handshake
// but are never stored.
//
// Ports
//   i_clk         rising-edge clock
//   i_reset       synchronous, active-low reset
//   i_src_data    packed sources, source k = i_src_data[k*DATA_W +: DATA_W]
//   i_sel         source select (NUM_SRC -> DEFAULT_VAL, above -> error)
//   i_in_addr     destination register of the offered transaction
//   i_in_valid    transaction offered
//   o_in_ready    queue can accept this cycle (registered state only)
//   o_out_data    head-of-queue data (last popped value while empty)
//   o_out_addr    head-of-queue register (last popped value while empty)
//   o_out_valid   head entry valid
//   i_out_ready   consumer takes the head entry this cycle
//   o_sel_err     sticky flag: an illegal select was accepted
//   i_err_clr     clears o_sel_err (a same-cycle set wins)
//   o_occupancy   number of stored entries
//------------------------------------------------------------------------------
module wb_select_queue #(
    parameter int                DATA_W      = 32,
    parameter int                NUM_SRC     = 11,
    parameter int                SEL_W       = 4,
    parameter int                ADDR_W      = 5,
    parameter int                DEPTH       = 2,
    parameter logic [DATA_W-1:0] DEFAULT_VAL = DATA_W'(227),
    parameter bit                DROP_ZERO   = 1'b1
) (
    input  logic                        i_clk,
    input  logic                        i_reset,
    input  logic [NUM_SRC*DATA_W-1:0]   i_src_data,
    input  logic [SEL_W-1:0]            i_sel,
    input  logic [ADDR_W-1:0]           i_in_addr,
    input  logic                        i_in_valid,
    output logic                        o_in_ready,
    output logic [DATA_W-1:0]           o_out_data,
    output logic [ADDR_W-1:0]           o_out_addr,
    output logic                        o_out_valid,
    input  logic                        i_out_ready,
    output logic                        o_sel_err,
    input  logic                        i_err_clr,
    output logic [$clog2(DEPTH):0]      o_occupancy
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;

    localparam logic [SEL_W-1:0] SEL_DEFAULT = SEL_W'(NUM_SRC);
    localparam logic [OCC_W-1:0] OCC_FULL    = OCC_W'(DEPTH);

    // Queue storage and control
    logic [DATA_W-1:0] r_data [DEPTH];
    logic [ADDR_W-1:0] r_addr [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [OCC_W-1:0]  r_occ;
    logic              r_sel_err;

    // Holds the most recently popped entry so the outputs stay stable
    // while the queue is empty; the slot under r_rd_ptr may contain stale
    // data from an earlier lap of the pointers.
    logic [DATA_W-1:0] r_last_data;
    logic [ADDR_W-1:0] r_last_addr;

    logic [DATA_W-1:0] w_sel_data;
    logic              w_sel_illegal;
    logic              w_in_ready;
    logic              w_out_valid;
    logic              w_accept;
    logic              w_push;
    logic              w_pop;
    logic              w_drop;

    //--------------------------------------------------------------------------
    // Source select. Every select value drives a defined result: anything
    // that does not match a real source falls through to DEFAULT_VAL.
    //--------------------------------------------------------------------------
    always_comb begin
        w_sel_data = DEFAULT_VAL;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (i_sel == SEL_W'(i)) begin
                w_sel_data = i_src_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign w_sel_illegal = (i_sel > SEL_DEFAULT);

    //--------------------------------------------------------------------------
    // Handshakes. in_ready depends only on occupancy, so a full queue refuses
    // new data even when the consumer pops in the same cycle.
    //--------------------------------------------------------------------------
    assign w_in_ready  = (r_occ < OCC_FULL);
    assign w_out_valid = (r_occ != '0);
    assign w_accept    = i_in_valid && w_in_ready;
    assign w_drop      = DROP_ZERO && (i_in_addr == '0);
    assign w_push      = w_accept && !w_drop;
    assign w_pop       = w_out_valid && i_out_ready;

    //--------------------------------------------------------------------------
    // State update
    //--------------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_data[i] <= '0;
                r_addr[i] <= '0;
            end
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_occ       <= '0;
            r_sel_err   <= 1'b0;
            r_last_data <= '0;
            r_last_addr <= '0;
        end else begin
            if (w_push) begin
                r_data[r_wr_ptr] <= w_sel_data;
                r_addr[r_wr_ptr] <= i_in_addr;
                r_wr_ptr         <= r_wr_ptr + PTR_W'(1);
            end

            if (w_pop) begin
                r_last_data <= r_data[r_rd_ptr];
                r_last_addr <= r_addr[r_rd_ptr];
                r_rd_ptr    <= r_rd_ptr + PTR_W'(1);
            end

            // Push is only possible below DEPTH and pop only above zero,
            // so occupancy cannot leave [0, DEPTH].
            case ({w_push, w_pop})
                2'b10:   r_occ <= r_occ + OCC_W'(1);
                2'b01:   r_occ <= r_occ - OCC_W'(1);
                default: r_occ <= r_occ;
            endcase

            // A new error outranks a clear arriving in the same cycle.
            if (w_accept && w_sel_illegal) begin
                r_sel_err <= 1'b1;
            end else if (i_err_clr) begin
                r_sel_err <= 1'b0;
            end
        end
    end

    //--------------------------------------------------------------------------
    // Outputs
    //--------------------------------------------------------------------------
    assign o_in_ready  = w_in_ready;
    assign o_out_valid = w_out_valid;
    assign o_out_data  = w_out_valid ? r_data[r_rd_ptr] : r_last_data;
    assign o_out_addr  = w_out_valid ? r_addr[r_rd_ptr] : r_last_addr;
    assign o_sel_err   = r_sel_err;
    assign o_occupancy = r_occ;

endmodule

// File: tb/tb_wb_select_queue.sv
module tb_wb_select_queue;

    localparam int DATA_W  = 32;
    localparam int NUM_SRC = 11;
    localparam int SEL_W   = 4;
    localparam int ADDR_W  = 5;
    localparam int DEPTH   = 2;
    localparam int DEF_VAL = 227;

    logic                      clk = 1'b0;
    logic                      i_reset;
    logic [NUM_SRC*DATA_W-1:0] i_src_data;
    logic [SEL_W-1:0]          i_sel;
    logic [ADDR_W-1:0]         i_in_addr;
    logic                      i_in_valid;
    logic                      o_in_ready;
    logic [DATA_W-1:0]         o_out_data;
    logic [ADDR_W-1:0]         o_out_addr;
    logic                      o_out_valid;
    logic                      i_out_ready;
    logic                      o_sel_err;
    logic                      i_err_clr;
    logic [$clog2(DEPTH):0]    o_occupancy;

    logic [DATA_W-1:0] src [NUM_SRC];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    always_comb begin
        i_src_data = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            i_src_data[i*DATA_W +: DATA_W] = src[i];
        end
    end

    wb_select_queue #(
        .DATA_W     (DATA_W),
        .NUM_SRC    (NUM_SRC),
        .SEL_W      (SEL_W),
        .ADDR_W     (ADDR_W),
        .DEPTH      (DEPTH),
        .DEFAULT_VAL(DATA_W'(DEF_VAL)),
        .DROP_ZERO  (1'b1)
    ) dut (
        .i_clk      (clk),
        .i_reset    (i_reset),
        .i_src_data (i_src_data),
        .i_sel      (i_sel),
        .i_in_addr  (i_in_addr),
        .i_in_valid (i_in_valid),
        .o_in_ready (o_in_ready),
        .o_out_data (o_out_data),
        .o_out_addr (o_out_addr),
        .o_out_valid(o_out_valid),
        .i_out_ready(i_out_ready),
        .o_sel_err  (o_sel_err),
        .i_err_clr  (i_err_clr),
        .o_occupancy(o_occupancy)
    );

    // ---------------- reference model / scoreboard ----------------
    typedef struct packed {
        logic [DATA_W-1:0] d;
        logic [ADDR_W-1:0] a;
    } ent_t;

    ent_t              exp_q[$];
    logic [DATA_W-1:0] m_last_d;
    logic [ADDR_W-1:0] m_last_a;
    logic              m_err;
    bit                armed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] ref_value(input int s);
        if (s < NUM_SRC) return src[s];
        return DATA_W'(DEF_VAL);
    endfunction

    // Outputs and inputs are both stable at the falling edge: inputs change
    // just after the rising edge. The model predicts the next rising edge.
    always @(negedge clk) begin
        bit   acc;
        bit   pop;
        ent_t e;
        if (armed) begin
            check("occupancy", 32'(o_occupancy), exp_q.size());
            check("out_valid", 32'(o_out_valid), (exp_q.size() != 0) ? 1 : 0);
            check("in_ready",  32'(o_in_ready),  (exp_q.size() < DEPTH) ? 1 : 0);
            check("sel_err",   32'(o_sel_err),   32'(m_err));
            if (exp_q.size() != 0) begin
                check("out_data", o_out_data,       exp_q[0].d);
                check("out_addr", 32'(o_out_addr),  32'(exp_q[0].a));
            end else begin
                check("idle_data", o_out_data,      m_last_d);
                check("idle_addr", 32'(o_out_addr), 32'(m_last_a));
            end
        end
        if (!i_reset) begin
            exp_q.delete();
            m_last_d = '0;
            m_last_a = '0;
            m_err    = 1'b0;
            armed    = 1;
        end else if (armed) begin
            acc = i_in_valid && (exp_q.size() < DEPTH);
            pop = (exp_q.size() != 0) && i_out_ready;
            if (pop) begin
                e = exp_q.pop_front();
                m_last_d = e.d;
                m_last_a = e.a;
            end
            if (acc && int'(i_sel) > NUM_SRC) m_err = 1'b1;
            else if (i_err_clr)              m_err = 1'b0;
            if (acc && i_in_addr != 0) begin
                e.d = ref_value(int'(i_sel));
                e.a = i_in_addr;
                exp_q.push_back(e);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input logic v, input logic [SEL_W-1:0] s, input logic [ADDR_W-1:0] a,
                        input logic r, input logic c);
        i_in_valid  = v;
        i_sel       = s;
        i_in_addr   = a;
        i_out_ready = r;
        i_err_clr   = c;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, '0, '0, 1'b1, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < NUM_SRC; i++) src[i] = 32'h1000_0000 + i;
        i_reset = 1'b0;
        i_in_valid = 0; i_sel = 0; i_in_addr = 0; i_out_ready = 0; i_err_clr = 0;
        @(posedge clk);
        #1;
        step(1'b0, '0, '0, 1'b0, 1'b0);
        i_reset = 1'b1;
        idle(1);

        // single transfer through source 3
        src[3] = 32'hDEAD_BEEF;
        step(1'b1, 4'd3, 5'd8, 1'b1, 1'b0);
        idle(2);

        // constant select, then illegal select with sticky error
        step(1'b1, 4'd11, 5'd4, 1'b1, 1'b0);
        step(1'b1, 4'd14, 5'd5, 1'b1, 1'b0);
        idle(3);
        step(1'b0, '0, '0, 1'b1, 1'b1);
        idle(1);
        // error set and clear in the same cycle: set wins
        step(1'b1, 4'd15, 5'd6, 1'b1, 1'b1);
        idle(1);
        step(1'b0, '0, '0, 1'b1, 1'b1);

        // fill to full, third push refused, then drain in order
        src[0] = 32'h11; src[1] = 32'h22; src[2] = 32'h33;
        step(1'b1, 4'd0, 5'd1, 1'b0, 1'b0);
        step(1'b1, 4'd1, 5'd2, 1'b0, 1'b0);
        step(1'b1, 4'd2, 5'd3, 1'b1, 1'b0);
        idle(3);

        // occupancy held at one with push and pop every cycle, pointers wrap
        step(1'b1, 4'd0, 5'd9, 1'b0, 1'b0);
        for (int k = 0; k < 8; k++) begin
            src[k % NUM_SRC] = 32'hA000_0000 + k;
            step(1'b1, 4'(k % NUM_SRC), 5'(10 + k), 1'b1, 1'b0);
        end
        idle(2);

        // write to register 0 dropped while its illegal select still counts
        step(1'b1, 4'd14, 5'd0, 1'b1, 1'b0);
        idle(2);
        step(1'b0, '0, '0, 1'b1, 1'b1);

        // reset with a full queue
        step(1'b1, 4'd1, 5'd7, 1'b0, 1'b0);
        step(1'b1, 4'd15, 5'd7, 1'b0, 1'b0);
        i_reset = 1'b0;
        step(1'b0, '0, '0, 1'b0, 1'b0);
        i_reset = 1'b1;
        idle(2);

        // randomized traffic
        for (int k = 0; k < 800; k++) begin
            for (int i = 0; i < NUM_SRC; i++) src[i] = $urandom;
            i_reset = ($urandom_range(0, 99) != 0);
            step($urandom_range(0, 3) != 0,
                 SEL_W'($urandom_range(0, 15)),
                 ($urandom_range(0, 6) == 0) ? '0 : ADDR_W'($urandom),
                 $urandom_range(0, 2) != 0,
                 $urandom_range(0, 9) == 0);
        end
        i_reset = 1'b1;
        idle(4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
